// File: rtl/fft_pkg.sv
// Shared definitions for the FFT/DFT sample path: loader state encoding
// and the addressing constants the compute controller also relies on.
package fft_pkg;

  localparam int FFT_ADDR_W    = 12;
  localparam int FFT_DATA_W    = 16;

  // Frames always start at sample RAM address 0 and may use every address
  // except the one that would require the counter to wrap.
  localparam int FFT_FIRST_ADR = 0;
  localparam int FFT_MAX_LEN   = (1 << FFT_ADDR_W) - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    DONE     = 2'd2,
    WAIT_CMP = 2'd3
  } state_t;

endpackage

// File: rtl/fft_sample_loader.sv
// Writer side of the sample-memory handshake: fills sample RAM with one
// frame from a valid/ready stream, then hands the buffer to the controller
// and locks out new samples until its compute phase has finished.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              load_nCompute,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_adr,
  output logic [DATA_W-1:0] wr_data,
  output logic              data_loaded,
  output logic              busy,
  output logic              cfg_err
);

  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FIRST_ADR = ADDR_W'(FFT_FIRST_ADR);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] len;
  logic              beat;
  logic              start_ok;
  logic              start_bad;
  logic              last_beat;

  assign s_ready   = ce & (state == FILL);
  assign beat      = s_valid & s_ready;
  assign busy      = (state != IDLE);
  assign start_ok  = (state == IDLE) & start & (sample_num != '0);
  assign start_bad = (state == IDLE) & start & (sample_num == '0);
  assign last_beat = beat & (count == (len - ONE));

  // State register; ce low freezes the FSM in place.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= next_state;
    end
  end

  // Next-state logic: fill one frame, hold it for the controller, then wait
  // for compute to finish before the buffer may be refilled.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_ok)       next_state = FILL;
      FILL:     if (last_beat)      next_state = DONE;
      DONE:     if (!load_nCompute) next_state = WAIT_CMP;
      WAIT_CMP: if (load_nCompute)  next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // Frame length capture and sample counter; the length is only sampled on
  // an accepted start so later sample_num changes cannot shorten a frame.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      len   <= '0;
      count <= '0;
    end else if (ce) begin
      if (start_ok) begin
        len   <= sample_num;
        count <= FIRST_ADR;
      end else if (beat) begin
        count <= count + ONE;
      end
    end
  end

  // Registered RAM write port: each accepted beat becomes a write one cycle
  // later, and a pending write simply holds while ce is low.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_en   <= 1'b0;
      wr_adr  <= '0;
      wr_data <= '0;
    end else if (ce) begin
      wr_en <= beat;
      if (beat) begin
        wr_adr  <= count;
        wr_data <= s_data;
      end
    end
  end

  // Status flags: data_loaded trails the final write by a cycle so the
  // controller never sees it before the last sample is in RAM.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      data_loaded <= 1'b0;
      cfg_err     <= 1'b0;
    end else if (ce) begin
      data_loaded <= (state == DONE) & load_nCompute;
      cfg_err     <= start_bad;
    end
  end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Writer side of the sample-memory handshake for the FFT/DFT controller.
- Accepts a valid/ready sample stream and writes `sample_num` samples into sample RAM at consecutive addresses from 0.
- Then raises `data_loaded` and holds it until the controller takes the buffer (`load_nCompute` falls).
- Refuses new samples until the controller finishes computing (`load_nCompute` rises again), so the buffer is never overwritten during compute.

Parameters:
- ADDR_W, 12, sample RAM address width; also the width of `sample_num`.
- DATA_W, 16, sample word width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset
- ce  in  1  clock enable; when low, all state, counters and outputs hold
- start  in  1  pulse; arms a fill of `sample_num` samples
- sample_num  in  ADDR_W  frame length; latched on accepted start
- s_valid  in  1  input sample valid
- s_data  in  DATA_W  input sample
- s_ready  out  1  loader can accept a sample this cycle
- load_nCompute  in  1  from controller; 1 = load phase, 0 = compute phase
- wr_en  out  1  sample RAM write strobe
- wr_adr  out  ADDR_W  sample RAM write address
- wr_data  out  DATA_W  sample RAM write data
- data_loaded  out  1  frame complete, level signal
- busy  out  1  high in every state except IDLE
- cfg_err  out  1  one-cycle pulse: start rejected because sample_num == 0

Behaviour:
- Reset is nrst, synchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE
  - wr_en = 0, wr_adr = 0, wr_data = 0
  - data_loaded = 0, busy = 0, cfg_err = 0
  - internal sample counter = 0, latched length = 0
- Reset mid-fill abandons the frame; samples already written are not cleared.
- All transitions and register updates occur only when ce = 1.
- s_ready is combinational: ce & (state == FILL). A beat transfers when s_valid & s_ready.
- IDLE:
  - start = 1 with sample_num != 0: latch the length, clear the counter, go to FILL.
  - start = 1 with sample_num == 0: pulse cfg_err for one cycle and stay in IDLE.
  - start is ignored in every other state.
- FILL:
  - Each accepted beat in cycle N produces, in cycle N+1: wr_en = 1, wr_adr = counter value at N, wr_data = s_data at N. The counter increments.
  - wr_en is 0 in every cycle not following an accepted beat.
  - When the accepted beat is number length-1, go to DONE. That beat's write appears in the first DONE cycle.
- DONE:
  - data_loaded goes to 1 registered, i.e. one cycle after the last wr_en, so the write is already committed.
  - Stay in DONE while load_nCompute = 1.
  - When load_nCompute = 0 is sampled: data_loaded goes to 0, go to WAIT_CMP.
- WAIT_CMP: wait for load_nCompute = 1, then go to IDLE. s_ready stays 0 throughout.
- Width rules:
  - The counter is ADDR_W bits.
  - Maximum length is 2^ADDR_W - 1. sample_num == 0 is illegal (see cfg_err).
  - No wrap-around occurs within a frame.
- Changes to sample_num after start are ignored until the next accepted start.
- Fill is not abortable except by nrst.
- Gaps:
  - s_valid gaps stall the fill without penalty.
  - ce-low cycles freeze everything, including a pending wr_en: it stays asserted, unchanged, until ce returns.
- busy = (state != IDLE).

Decomposition:
- Shared package fft_pkg holds:
  - the state enum typedef (IDLE, FILL, DONE, WAIT_CMP, 2-bit)
  - the ADDR_W/DATA_W defaults
  - the same addressing constants the compute controller uses for `sample_num`.
- No sub-module. The design is a single FSM plus counter and write register; about 150 lines of RTL.

Test Plan:
- Basic fill, no stalls:
  - Stimulus: start with sample_num = 4; beats 0xA0..0xA3 with s_valid held high; load_nCompute = 1.
  - Response: wr_en for 4 consecutive cycles at wr_adr 0..3 with data A0..A3; data_loaded = 1 one cycle after the last wr_en and held; s_ready = 0 after the 4th beat.
- Controller handshake:
  - Stimulus: continuing the basic fill, drop load_nCompute for 10 cycles, then raise it.
  - Response: data_loaded falls the cycle after load_nCompute = 0 is sampled; busy stays high through WAIT_CMP; state is IDLE one cycle after load_nCompute returns to 1. Beats offered during WAIT_CMP are not accepted.
- Stall and ce:
  - Stimulus: sample_num = 3; s_valid toggles 1,0,1,0,1; ce held low for 2 cycles mid-frame.
  - Response: exactly 3 writes at addresses 0,1,2 with the correct data; a pending wr_en persists unchanged across the ce-low cycles; no duplicate writes.
- Illegal length:
  - Stimulus: start with sample_num = 0.
  - Response: cfg_err pulses for exactly 1 cycle; busy stays 0; no wr_en.
- Config change and reset mid-fill:
  - Stimulus: start with sample_num = 8; change sample_num to 2 during FILL; after 5 beats, assert nrst = 0 for 1 cycle.
  - Response: the sample_num change has no effect (still waiting after 2 beats). After reset, all outputs return to reset values and the next start with sample_num = 2 writes addresses 0,1 and asserts data_loaded.
- Maximum length:
  - Stimulus: sample_num = 4095.
  - Response: last wr_adr = 4094; data_loaded asserts; the counter does not wrap to 0 within the frame.
